// File: rtl/calc_mailbox_host.sv
// Calculator-side mailbox initiator: writes two operands and an opcode into
// shared data-memory words, posts a request flag, polls for completion, reads
// the result back and clears the flag.
module calc_mailbox_host #(
    parameter logic [31:0] OPA_ADDR  = 32'h0000_0000,
    parameter logic [31:0] OPB_ADDR  = 32'h0000_0004,
    parameter logic [31:0] OPC_ADDR  = 32'h0000_0008,
    parameter logic [31:0] FLAG_ADDR = 32'h0000_000C,
    parameter logic [31:0] RES_ADDR  = 32'h0000_0010,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  opcode,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic [31:0] EntradaCalcu,
    output logic [31:0] addressCalcu,
    output logic        writeEnableCalcu,
    input  logic [31:0] resultadoCalcu
);

    // Wide enough to hold TIMEOUT itself, so the counter can never wrap.
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [31:0] FlagIdle  = 32'd0;
    localparam logic [31:0] FlagReq   = 32'd1;
    localparam logic [31:0] FlagReady = 32'd2;

    typedef enum logic [3:0] {
        StIdle,
        StWrA,
        StWrB,
        StWrOpc,
        StWrReq,
        StPollRd,
        StPollChk,
        StRdRes,
        StResChk,
        StClr,
        StDone
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [31:0]     opa_q;
    logic [31:0]     opb_q;
    logic [3:0]      opc_q;
    logic [31:0]     opa_d;
    logic [31:0]     opb_d;
    logic [3:0]      opc_d;
    logic [CntW-1:0] poll_cnt_q;
    logic            accept;
    logic            timed_out;

    logic            we_d;
    logic [31:0]     addr_d;
    logic [31:0]     data_d;

    assign accept    = (state_q == StIdle) && start;
    assign timed_out = (state_q == StPollChk) && (state_d == StClr);

    // Operands seen by the output decode: the live inputs on the accepting
    // edge, the latched copies otherwise.
    assign opa_d = accept ? operand_a : opa_q;
    assign opb_d = accept ? operand_b : opb_q;
    assign opc_d = accept ? opcode    : opc_q;

    // Next-state logic of the mailbox protocol sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StWrA;
            StWrA:     state_d = StWrB;
            StWrB:     state_d = StWrOpc;
            StWrOpc:   state_d = StWrReq;
            StWrReq:   state_d = StPollRd;
            StPollRd:  state_d = StPollChk;
            StPollChk: begin
                if (resultadoCalcu == FlagReady) begin
                    state_d = StRdRes;
                end else if (poll_cnt_q == CntLast) begin
                    state_d = StClr;
                end else begin
                    state_d = StPollRd;
                end
            end
            StRdRes:   state_d = StResChk;
            StResChk:  state_d = StClr;
            StClr:     state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Memory-side values for the state about to be entered; the address
    // holds its last value in states that do not touch the mailbox.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addressCalcu;
        data_d = '0;
        unique case (state_d)
            StWrA: begin
                we_d   = 1'b1;
                addr_d = OPA_ADDR;
                data_d = opa_d;
            end
            StWrB: begin
                we_d   = 1'b1;
                addr_d = OPB_ADDR;
                data_d = opb_d;
            end
            StWrOpc: begin
                we_d   = 1'b1;
                addr_d = OPC_ADDR;
                data_d = {28'b0, opc_d};
            end
            StWrReq: begin
                we_d   = 1'b1;
                addr_d = FLAG_ADDR;
                data_d = FlagReq;
            end
            StPollRd: addr_d = FLAG_ADDR;
            StRdRes:  addr_d = RES_ADDR;
            StClr: begin
                we_d   = 1'b1;
                addr_d = FLAG_ADDR;
                data_d = FlagIdle;
            end
            default: ;
        endcase
    end

    // State, latched request, poll counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            opa_q            <= '0;
            opb_q            <= '0;
            opc_q            <= '0;
            poll_cnt_q       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            result           <= '0;
            EntradaCalcu     <= '0;
            addressCalcu     <= '0;
            writeEnableCalcu <= 1'b0;
        end else begin
            state_q          <= state_d;
            opa_q            <= opa_d;
            opb_q            <= opb_d;
            opc_q            <= opc_d;
            busy             <= (state_d != StIdle);
            done             <= (state_d == StDone);
            EntradaCalcu     <= data_d;
            addressCalcu     <= addr_d;
            writeEnableCalcu <= we_d;

            if (accept) begin
                error      <= 1'b0;
                poll_cnt_q <= '0;
            end else if ((state_q == StPollChk) && (state_d == StPollRd)) begin
                poll_cnt_q <= poll_cnt_q + CntW'(1);
            end

            if (timed_out) begin
                error <= 1'b1;
            end

            // Read data for RES_ADDR arrives in the cycle after RD_RES.
            if (state_q == StResChk) begin
                result <= resultadoCalcu;
            end
        end
    end

endmodule

// File: tb/tb_calc_mailbox_host.sv
// Directed bench for calc_mailbox_host: a table of transactions against a
// mailbox memory with a scripted firmware responder, a short-timeout second
// instance, and hand sequences for reset mid-poll.
module tb_calc_mailbox_host;

    localparam logic [31:0] OPA  = 32'h0000_0000;
    localparam logic [31:0] OPB  = 32'h0000_0004;
    localparam logic [31:0] OPC  = 32'h0000_0008;
    localparam logic [31:0] FLAG = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  opc;

    logic        busy, done, error, we;
    logic [31:0] result, wdata, waddr, rdata;
    logic        busy2, done2, error2, we2;
    logic [31:0] result2, wdata2, waddr2, rdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_mailbox_host #(.TIMEOUT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .operand_a        (op_a),
        .operand_b        (op_b),
        .opcode           (opc),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .result           (result),
        .EntradaCalcu     (wdata),
        .addressCalcu     (waddr),
        .writeEnableCalcu (we),
        .resultadoCalcu   (rdata)
    );

    calc_mailbox_host #(.TIMEOUT(4)) dut2 (
        .clk              (clk),
        .reset            (reset),
        .start            (start2),
        .operand_a        (op_a),
        .operand_b        (op_b),
        .opcode           (opc),
        .busy             (busy2),
        .done             (done2),
        .error            (error2),
        .result           (result2),
        .EntradaCalcu     (wdata2),
        .addressCalcu     (waddr2),
        .writeEnableCalcu (we2),
        .resultadoCalcu   (rdata2)
    );

    // Mailbox memory with registered read and a scripted firmware responder.
    logic [31:0] mem [0:7];
    logic        posted;
    int          fw_cnt;
    int          fw_delay;
    int          fw_garb;
    logic [31:0] fw_res;

    always @(posedge clk) begin
        if (reset) begin
            posted <= 1'b0;
            fw_cnt <= 0;
        end else begin
            if (posted) begin
                fw_cnt <= fw_cnt + 1;
                if (fw_garb != 0 && fw_cnt == fw_garb) mem[3] <= 32'd3;
                if (fw_cnt == fw_delay) begin
                    mem[3] <= 32'd2;
                    mem[4] <= fw_res;
                    posted <= 1'b0;
                end
            end
            if (we) begin
                mem[waddr[4:2]] <= wdata;
                if (waddr == FLAG) begin
                    if (wdata == 32'd1) begin
                        if (fw_delay == 0) begin
                            mem[3] <= 32'd2;
                            mem[4] <= fw_res;
                            posted <= 1'b0;
                        end else begin
                            posted <= 1'b1;
                            fw_cnt <= 1;
                        end
                    end else begin
                        posted <= 1'b0;
                    end
                end
            end
        end
        rdata <= mem[waddr[4:2]];
    end

    // Second mailbox: answers immediately with 0xDEADBEEF or never.
    logic [31:0] mem2 [0:7];
    logic        fw2_auto;

    always @(posedge clk) begin
        if (we2) mem2[waddr2[4:2]] <= wdata2;
        if (we2 && waddr2 == FLAG && wdata2 == 32'd1 && fw2_auto) begin
            mem2[3] <= 32'd2;
            mem2[4] <= 32'hDEAD_BEEF;
        end
        rdata2 <= mem2[waddr2[4:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        int          delay;
        int          garb;
        logic [31:0] res;
        logic        poke;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    // Runs one transaction on the main instance from an idle cycle and
    // returns in the idle cycle after DONE.
    task automatic run_vec(input vec_t v);
        logic [31:0] wa [8];
        logic [31:0] wd [8];
        int          n   = 0;
        int          cyc = 0;
        bit          got = 1'b0;
        fw_delay = v.delay;
        fw_garb  = v.garb;
        fw_res   = v.res;
        op_a     = v.a;
        op_b     = v.b;
        opc      = v.op;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!got && cyc < 100) begin
            cyc++;
            if (!busy) check({v.name, " busy"}, 32'(busy), 32'd1);
            if (we && n < 8) begin
                wa[n] = waddr;
                wd[n] = wdata;
                n++;
            end
            if (v.poke && cyc == 5) begin
                start = 1'b1;
                op_a  = 32'h7777_7777;
                op_b  = 32'h6666_6666;
                opc   = 4'hE;
            end
            if (v.poke && cyc == 6) start = 1'b0;
            if (done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check({v.name, " done seen"}, 32'(got), 32'd1);
        check({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
        check({v.name, " result"}, result, v.exp_res);
        check({v.name, " error"}, 32'(error), 32'(v.exp_err));
        check({v.name, " write count"}, 32'(n), 32'd5);
        if (n == 5) begin
            check({v.name, " wr0 addr"}, wa[0], OPA);
            check({v.name, " wr0 data"}, wd[0], v.a);
            check({v.name, " wr1 addr"}, wa[1], OPB);
            check({v.name, " wr1 data"}, wd[1], v.b);
            check({v.name, " wr2 addr"}, wa[2], OPC);
            check({v.name, " wr2 data"}, wd[2], {28'b0, v.op});
            check({v.name, " wr3 addr"}, wa[3], FLAG);
            check({v.name, " wr3 data"}, wd[3], 32'd1);
            check({v.name, " clr addr"}, wa[4], FLAG);
            check({v.name, " clr data"}, wd[4], 32'd0);
        end
        @(posedge clk);
        #1;
        check({v.name, " busy after"}, 32'(busy), 32'd0);
        check({v.name, " done after"}, 32'(done), 32'd0);
        check({v.name, " error hold"}, 32'(error), 32'(v.exp_err));
    endtask

    // Runs one transaction on the short-timeout instance.
    task automatic run2(output int lat, output int nw, output logic [31:0] la,
                        output logic [31:0] ld);
        bit got = 1'b0;
        lat = 0;
        nw  = 0;
        la  = '0;
        ld  = '0;
        op_a   = 32'h1;
        op_b   = 32'h2;
        opc    = 4'h3;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        while (!got && lat < 100) begin
            lat++;
            if (we2) begin
                nw++;
                la = waddr2;
                ld = wdata2;
            end
            if (done2) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("t4 done seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        int          nw;
        logic [31:0] la;
        logic [31:0] ld;

        vecs[0] = '{"basic", 32'd5, 32'd7, 4'd1, 0, 0, 32'd12, 1'b0, 32'd12, 1'b0, 10};
        vecs[1] = '{"delay1", 32'h1111_0000, 32'h0000_2222, 4'hF, 1, 0, 32'h111, 1'b0,
                    32'h111, 1'b0, 12};
        vecs[2] = '{"delay20", 32'hFFFF_FFFF, 32'h8000_0001, 4'd3, 20, 0, 32'h1234, 1'b0,
                    32'h1234, 1'b0, 30};
        vecs[3] = '{"garbage", 32'd1, 32'd2, 4'd4, 3, 1, 32'hCAFE, 1'b0, 32'hCAFE, 1'b0, 14};
        vecs[4] = '{"ignored", 32'd9, 32'd3, 4'd2, 4, 0, 32'h2222, 1'b1, 32'h2222, 1'b0, 14};
        vecs[5] = '{"timeout16", 32'hA, 32'hB, 4'd5, 1000, 0, 32'h9999, 1'b0, 32'h2222, 1'b1,
                    38};
        vecs[6] = '{"recover", 32'd6, 32'd6, 4'd6, 0, 0, 32'h55, 1'b0, 32'h55, 1'b0, 10};

        reset    = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        op_a     = '0;
        op_b     = '0;
        opc      = '0;
        fw_delay = 0;
        fw_garb  = 0;
        fw_res   = '0;
        fw2_auto = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst result", result, 32'd0);
        check("rst we", 32'(we), 32'd0);
        check("rst addr", waddr, 32'd0);
        check("rst data", wdata, 32'd0);

        // Short-timeout instance: a good result first, then a timeout.
        run2(lat, nw, la, ld);
        check("t4 ok latency", 32'(lat), 32'd10);
        check("t4 ok result", result2, 32'hDEAD_BEEF);
        check("t4 ok error", 32'(error2), 32'd0);
        fw2_auto = 1'b0;
        run2(lat, nw, la, ld);
        check("t4 to latency", 32'(lat), 32'd14);
        check("t4 to result", result2, 32'hDEAD_BEEF);
        check("t4 to error", 32'(error2), 32'd1);
        check("t4 to writes", 32'(nw), 32'd5);
        check("t4 to clr addr", la, FLAG);
        check("t4 to clr data", ld, 32'd0);
        check("t4 flag cleared", mem2[3], 32'd0);
        check("t4 busy idle", 32'(busy2), 32'd0);

        // Table of back-to-back transactions on the main instance.
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while sitting in POLL_CHK.
        fw_delay = 20;
        fw_garb  = 0;
        fw_res   = 32'h4444;
        op_a     = 32'd3;
        op_b     = 32'd4;
        opc      = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-rst poll addr", waddr, FLAG);
        check("pre-rst poll we", 32'(we), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst we", 32'(we), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (we) check("midrst stray write", 32'(we), 32'd0);
        end
        check("midrst stale flag", mem[3], 32'd1);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_mailbox_host.md
# calc_mailbox_host

Calculator-side initiator for the shared data-memory mailbox port (EntradaCalcu / addressCalcu / writeEnableCalcu / resultadoCalcu) exposed by the Mem stage. Accepts one calculation request (two operands plus opcode) from the calculator front panel and writes it into fixed mailbox words. It then raises a request flag, polls the flag until the ARM program reports completion, reads back the result, and clears the flag. This block is the host end of the protocol whose responder is the firmware running on the ARM core.

## Interface
Parameters:
- OPA_ADDR, 32'h0000_0000, mailbox word for operand A
- OPB_ADDR, 32'h0000_0004, mailbox word for operand B
- OPC_ADDR, 32'h0000_0008, mailbox word for opcode (zero-extended)
- FLAG_ADDR, 32'h0000_000C, handshake flag word
- RES_ADDR, 32'h0000_0010, result word
- TIMEOUT, 1024, maximum number of flag polls before abort (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  request pulse; sampled only in IDLE
- operand_a  in  32  operand A, latched when start is accepted
- operand_b  in  32  operand B, latched when start is accepted
- opcode  in  4  operation code, latched when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a transaction ends (success or timeout)
- error  out  1  valid with done; 1 = timeout abort; holds until next accepted start
- result  out  32  last result; holds until next done
- EntradaCalcu  out  32  mailbox write data
- addressCalcu  out  32  mailbox address
- writeEnableCalcu  out  1  mailbox write strobe, one word per cycle
- resultadoCalcu  in  32  mailbox read data

## Operation
- Flag encoding: 0 = idle, 1 = request posted by host, 2 = result ready (written by firmware). Any other value is treated as "not ready".
- States and transitions:
  - IDLE: start=1 → WR_A, latching operands and opcode, clearing error and the poll counter.
  - WR_A → WR_B → WR_OPC → WR_REQ: each writes one word (A, B, {28'b0,opcode}, 32'd1) to its address with writeEnableCalcu=1.
  - POLL_RD: address=FLAG_ADDR, we=0 → POLL_CHK.
  - POLL_CHK: sample resultadoCalcu.
    - If ==2 → RD_RES.
    - Else, if poll count+1 == TIMEOUT → CLR with error set.
    - Else increment count → POLL_RD.
  - RD_RES: address=RES_ADDR, we=0 → RES_CHK.
  - RES_CHK: result ← resultadoCalcu → CLR.
  - CLR: write 32'd0 to FLAG_ADDR → DONE.
  - DONE: done=1 → IDLE.
- Memory-side outputs are a Moore decode of the registered state and latched operands. In non-write states EntradaCalcu=0, and addressCalcu holds the last driven address.
- Mailbox read data is valid the cycle after the address is presented; the sample is taken in the following state (POLL_CHK, RES_CHK).
- On timeout: result is unchanged, error=1, and the flag is still cleared in CLR.
- start while busy is ignored, and is not queued.
- Poll counter width is clog2(TIMEOUT+1). It saturates by construction and never wraps.

## Timing
- Reset values:
  - state IDLE
  - busy 0, done 0, error 0
  - result 0
  - EntradaCalcu 0, addressCalcu 0, writeEnableCalcu 0
- Reset mid-transaction: the next cycle is IDLE with writeEnableCalcu=0. No flag-clear write is issued; firmware must tolerate a stale flag of 1.
- Minimum latency when the flag reads 2 on the first poll: start sampled at edge k; WR_A at cycle k+1; done high in cycle k+10.
- Each additional unsuccessful poll adds 2 cycles.
- Timeout path: done arrives 4 + 2·TIMEOUT + 2 cycles after acceptance.
- busy rises in the cycle after start is accepted and falls in the cycle after DONE. done and busy are both high in the DONE cycle.
- Back-to-back: start asserted in the cycle after DONE (state IDLE) is accepted.

## Test plan
- Basic: A=5, B=7, opcode=1; memory model sets flag=2 and result=12 after the request write → exactly four write cycles, each with writeEnableCalcu=1:
  - 0x0: 5
  - 0x4: 7
  - 0x8: 1
  - 0xC: 1
  - Then result=12, error=0, done 10 cycles after start, and a final write of 0 to 0xC.
- Delayed responder: flag becomes 2 after 20 cycles → result correct, done count matches the 2-cycle-per-poll rule, no extra writes during polling.
- Timeout: TIMEOUT=4 and the flag is never set → done with error=1, result unchanged (prior value 0xDEADBEEF), flag cleared, 14 cycles total.
- Ignored start: pulse start during POLL_RD with different operands → no new writes; the original transaction completes with the original operands.
- Reset mid-poll: assert reset in POLL_CHK → next cycle IDLE, busy=0, writeEnableCalcu=0, no write to 0xC; a subsequent start runs normally.
- Garbage flag: flag reads 3 then 2 → 3 is treated as not ready, completion on 2.
